// File: rtl/mode_rate_strobe.sv
// Mode-dependent clock-enable strobe generator with stretched downstream reset.
// Each controller mode owns a run-time programmable divisor; mode changes and
// divisor updates only take effect on a strobe boundary, so no period is ever
// cut short or stretched.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_HOLD | downstream reset held (rst_out=1), hold counter running
// ST_RUN  | strobe generation, one strobe every div_eff cycles
module mode_rate_strobe #(
    parameter int NUM_MODES   = 4,
    parameter int MODE_W      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int FAST_MODE_A = 1,
    parameter int FAST_MODE_B = 2,
    parameter int RST_HOLD    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode_in,
    input  logic              cfg_we,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              strobe,
    output logic              rst_out,
    output logic [MODE_W-1:0] mode_active,
    output logic              switch_pend,
    output logic [DIV_W-1:0]  cnt
);

    localparam int IDX_W        = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int HOLD_W       = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int HOLD_LAST_I  = RST_HOLD - 1;
    localparam int MODE_LIMIT_I = NUM_MODES;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_LAST_I[HOLD_W-1:0];
    localparam logic [MODE_W:0]   MODE_LIMIT = MODE_LIMIT_I[MODE_W:0];

    typedef enum logic {
        ST_HOLD,
        ST_RUN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [DIV_W-1:0]  div_q [NUM_MODES];
    logic [MODE_W-1:0] mode_sel;
    logic              cfg_ok;
    logic              boundary;
    logic [DIV_W-1:0]  reload_div;
    logic [DIV_W-1:0]  reload_cnt;

    // Out-of-range modes fall back to mode 0; out-of-range writes are dropped.
    assign mode_sel = ({1'b0, mode_in} < MODE_LIMIT) ? mode_in : '0;
    assign cfg_ok   = cfg_we && ({1'b0, cfg_mode} < MODE_LIMIT);

    // A write landing on the reload cycle for the incoming mode is forwarded.
    assign reload_div = (cfg_we && (cfg_mode == mode_sel)) ? cfg_div
                                                           : div_q[mode_sel[IDX_W-1:0]];
    // Divisor 0 behaves like 1: reload to 0 so the strobe fires every cycle.
    assign reload_cnt = (reload_div == '0) ? '0 : reload_div - DIV_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and the state-derived outputs.
    always_comb begin
        state_d  = state_q;
        rst_out  = 1'b1;
        boundary = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rst_out  = 1'b0;
                boundary = (cnt == '0);
            end
            default: state_d = ST_HOLD;
        endcase
    end

    assign strobe = boundary;

    // Hold counter, period counter, active mode, pending flag and divisor bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            mode_active <= '0;
            switch_pend <= 1'b0;
            cnt         <= '0;
            for (int i = 0; i < NUM_MODES; i++) begin
                div_q[i] <= ((i == FAST_MODE_A) || (i == FAST_MODE_B)) ? DIV_W'(1)
                                                                        : DIV_W'(DEFAULT_DIV);
            end
        end else begin
            if (cfg_ok) begin
                div_q[cfg_mode[IDX_W-1:0]] <= cfg_div;
            end
            case (state_q)
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        mode_active <= mode_sel;
                        cnt         <= '0;
                        switch_pend <= 1'b0;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (boundary) begin
                        // The switch completes here, so nothing remains pending.
                        mode_active <= mode_sel;
                        cnt         <= reload_cnt;
                        switch_pend <= 1'b0;
                    end else begin
                        cnt         <= cnt - DIV_W'(1);
                        switch_pend <= (mode_sel != mode_active);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mode_rate_strobe.sv
// Bench for mode_rate_strobe: directed vector table, hand-written corner
// sequences and random traffic, all compared against an elapsed-time model.
module tb_mode_rate_strobe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode_in = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_mode = '0;
    logic [7:0] cfg_div = '0;
    logic       strobe;
    logic       rst_out;
    logic [2:0] mode_active;
    logic       switch_pend;
    logic [7:0] cnt;

    always #5 clk = ~clk;

    mode_rate_strobe #(
        .NUM_MODES  (4),
        .MODE_W     (3),
        .DIV_W      (8),
        .DEFAULT_DIV(4),
        .FAST_MODE_A(1),
        .FAST_MODE_B(2),
        .RST_HOLD   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_in    (mode_in),
        .cfg_we     (cfg_we),
        .cfg_mode   (cfg_mode),
        .cfg_div    (cfg_div),
        .strobe     (strobe),
        .rst_out    (rst_out),
        .mode_active(mode_active),
        .switch_pend(switch_pend),
        .cnt        (cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: time elapsed since the last strobe against the period.
    int m_valid = 0;
    int m_run, m_rel, m_ma, m_pend, m_e, m_p;
    int m_div [4];

    function automatic int model_packed();
        int s, ro, c;
        s  = (m_run != 0 && m_e == 0) ? 1 : 0;
        ro = (m_run != 0) ? 0 : 1;
        c  = (m_run == 0 || m_e == 0) ? 0 : (m_p - m_e);
        return (s << 13) | (ro << 12) | (m_ma << 9) | (m_pend << 8) | c;
    endfunction

    task automatic model_update(input int r, input int m, input int we, input int cm, input int cd);
        int ms, nd;
        ms = (m < 4) ? m : 0;
        if (r != 0) begin
            m_run = 0; m_rel = 0; m_ma = 0; m_pend = 0; m_e = 0; m_p = 1;
            for (int i = 0; i < 4; i++) m_div[i] = (i == 1 || i == 2) ? 1 : 4;
        end else begin
            if (m_run == 0) begin
                m_rel++;
                if (m_rel == 3) begin
                    m_run = 1; m_ma = ms; m_e = 0; m_pend = 0;
                end
            end else if (m_e == 0) begin
                nd     = (we != 0 && cm == ms) ? cd : m_div[ms];
                m_p    = (nd == 0) ? 1 : nd;
                m_ma   = ms;
                m_pend = 0;
                m_e    = (m_p == 1) ? 0 : 1;
            end else begin
                m_e++;
                if (m_e == m_p) m_e = 0;
                m_pend = (ms != m_ma) ? 1 : 0;
            end
            if (we != 0 && cm < 4) m_div[cm] = cd;
        end
    endtask

    logic       obs_s, obs_ro, obs_sp;
    logic [2:0] obs_ma;
    logic [7:0] obs_c;

    // One clock cycle: drive inputs, sample outputs, compare to model, advance.
    task automatic step(input int r, input int m, input int we, input int cm, input int cd);
        @(negedge clk);
        rst = (r != 0); mode_in = 3'(m); cfg_we = (we != 0);
        cfg_mode = 3'(cm); cfg_div = 8'(cd);
        #1;
        obs_s = strobe; obs_ro = rst_out; obs_sp = switch_pend;
        obs_ma = mode_active; obs_c = cnt;
        if (m_valid != 0)
            chk("model", int'({strobe, rst_out, mode_active, switch_pend, cnt}), model_packed());
        @(posedge clk);
        model_update(r, m, we, cm, cd);
        m_valid = 1;
    endtask

    task automatic wait_cnt(input string name, input int target, input int m, input int limit);
        int found;
        found = 0;
        for (int i = 0; i < limit && found == 0; i++) begin
            step(0, m, 0, 0, 0);
            if (int'(obs_c) == target) found = 1;
        end
        chk(name, found, 1);
    endtask

    typedef struct {
        int r; int m; int we; int cm; int cd;
        int s; int ro; int ma; int sp; int c;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(int m, int we, int cm, int cd, int s, int ro, int ma, int sp, int c);
        vec_t v;
        v.r = 0; v.m = m; v.we = we; v.cm = cm; v.cd = cd;
        v.s = s; v.ro = ro; v.ma = ma; v.sp = sp; v.c = c;
        return v;
    endfunction

    initial begin
        int cur_m;
        int found;

        // reset release, mode 0 at period 4, switch to mode 1, then mode 3 with a mid-count write
        tbl[0]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[11] = mk(1, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[12] = mk(1, 0, 0, 0, 1, 0, 1, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 1, 0, 1, 0, 0);
        tbl[14] = mk(3, 0, 0, 0, 1, 0, 1, 0, 0);
        tbl[15] = mk(3, 0, 0, 0, 0, 0, 3, 0, 3);
        tbl[16] = mk(3, 0, 0, 0, 0, 0, 3, 0, 2);
        tbl[17] = mk(3, 1, 3, 6, 0, 0, 3, 0, 1);
        tbl[18] = mk(3, 0, 0, 0, 1, 0, 3, 0, 0);
        tbl[19] = mk(3, 0, 0, 0, 0, 0, 3, 0, 5);
        tbl[20] = mk(3, 0, 0, 0, 0, 0, 3, 0, 4);

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].r, tbl[i].m, tbl[i].we, tbl[i].cm, tbl[i].cd);
            chk($sformatf("vec%0d", i),
                int'({obs_s, obs_ro, obs_ma, obs_sp, obs_c}),
                (tbl[i].s << 13) | (tbl[i].ro << 12) | (tbl[i].ma << 9) | (tbl[i].sp << 8) | tbl[i].c);
        end

        // write on a reload cycle is used by that very reload
        wait_cnt("reach_cnt1_a", 1, 3, 20);
        step(0, 3, 1, 3, 7);
        chk("bypass_strobe", int'(obs_s), 1);
        step(0, 3, 0, 0, 0);
        chk("bypass_reload", int'(obs_c), 6);

        // divisor 0 on mode 0 gives a strobe every cycle; out-of-range write ignored
        wait_cnt("reach_cnt1_b", 1, 0, 20);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("div0_strobe%0d", i), int'({obs_s, obs_ma}), 8);
        end
        step(0, 0, 1, 5, 9);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("cfg5_strobe%0d", i), int'(obs_s), 1);
        end
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("mode1_active", int'(obs_ma), 1);
        chk("mode1_strobe", int'(obs_s), 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // 0 -> 2 -> 0 inside one period: no switch, period stays 4
        step(0, 0, 1, 0, 4);
        chk("toggle_start", int'(obs_s), 1);
        step(0, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("toggle_pend", int'(obs_sp), 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("toggle_boundary", int'({obs_s, obs_ma}), 8);
        step(0, 0, 0, 0, 0);
        chk("toggle_period", int'({obs_ma, obs_c}), 3);

        // reset mid-period in mode 3 at divisor 6
        step(0, 3, 1, 3, 6);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            step(0, 3, 0, 0, 0);
            if (obs_ma == 3'd3 && obs_c == 8'd3) found = 1;
        end
        chk("reach_mode3_mid", found, 1);
        step(1, 3, 0, 0, 0);
        step(0, 3, 0, 0, 0);
        chk("midrst_outputs", int'({obs_s, obs_ro, obs_ma, obs_sp, obs_c}), 1 << 12);
        step(0, 3, 0, 0, 0);
        step(0, 3, 0, 0, 0);
        chk("midrst_hold", int'(obs_ro), 1);
        step(0, 3, 0, 0, 0);
        chk("midrst_run", int'({obs_s, obs_ro, obs_ma}), (1 << 4) | 3);
        step(0, 3, 0, 0, 0);
        chk("midrst_default_div", int'(obs_c), 3);

        // random traffic against the model
        cur_m = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) cur_m = int'($urandom_range(0, 7));
            step(($urandom_range(0, 149) == 0) ? 1 : 0, cur_m,
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 9)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mode_rate_strobe.md
Name: mode_rate_strobe

Overview:
- Synthesizable successor to the testbench-only, state-dependent clock switching in the top-level bench.
- Generates a single-cycle clock-enable strobe whose rate depends on the accelerator controller mode (IDLE / MEM_LOAD / MEM_SAVE / COMPUTATION, or more modes). Each mode has its own divisor, programmable at run time.
- Mode changes are glitch-free: they are applied only at a strobe boundary.
- Also sequences a stretched reset for downstream logic. Sits between the controller and the strobe-gated datapath/memory interface.

Parameters:
- NUM_MODES, 4, number of controller modes with their own divisor.
- MODE_W, 2, width of mode codes; NUM_MODES <= 2**MODE_W.
- DIV_W, 8, width of each divisor register.
- DEFAULT_DIV, 4, reset divisor for every mode except FAST_MODE_A and FAST_MODE_B.
- FAST_MODE_A, 1, mode whose divisor resets to 1 (MEM_LOAD).
- FAST_MODE_B, 2, mode whose divisor resets to 1 (MEM_SAVE).
- RST_HOLD, 3, number of cycles rst_out stays high after rst deasserts.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mode_in  in  MODE_W  current controller state
- cfg_we  in  1  divisor write enable
- cfg_mode  in  MODE_W  mode whose divisor is written
- cfg_div  in  DIV_W  new divisor value
- strobe  out  1  one-cycle clock enable
- rst_out  out  1  stretched synchronous reset for downstream logic
- mode_active  out  MODE_W  mode whose divisor currently governs strobe
- switch_pend  out  1  mode_in differs from mode_active; switch waiting for a boundary
- cnt  out  DIV_W  cycles remaining until the next strobe

Behaviour:
- Single clock domain. rst is sampled on the clk rising edge only.
- Reset values (rst=1): strobe=0, rst_out=1, mode_active=0, switch_pend=0, cnt=0, state=HOLD, hold counter=0.
- Divisor reset values: FAST_MODE_A and FAST_MODE_B = 1; all other modes = DEFAULT_DIV.
- Effective divisor: div_eff = (div==0) ? 1 : div.
- cfg_we with cfg_mode >= NUM_MODES is ignored.
- FSM state HOLD:
  - rst_out=1, strobe=0.
  - Hold counter increments each cycle after rst deasserts.
  - When the counter reaches RST_HOLD-1: go to RUN, mode_active <= mode_in, cnt <= 0.
  - With RST_HOLD=3, rst_out first reads 0 on the 3rd cycle after rst falls.
- FSM state RUN, rst_out=0:
  - strobe = (cnt==0), combinational from registered cnt.
  - The first strobe occurs on the first RUN cycle.
  - If cnt==0: cnt <= div_eff(next mode)-1. Otherwise cnt <= cnt-1.
  - Strobe period is exactly div_eff cycles. div_eff=1 gives strobe held high every cycle.
- Mode switch:
  - switch_pend = (mode_in != mode_active) in RUN, registered one cycle after mode_in changes.
  - mode_active updates only on a cycle with cnt==0. The reload then uses the divisor of mode_in sampled that cycle.
  - A mode_in that changes and returns before a boundary causes no switch.
  - No strobe is ever shortened or lengthened mid-period.
  - mode_in >= NUM_MODES is treated as mode 0.
- Config write:
  - Takes effect at the next reload, never mid-count.
  - A write on the same cycle as a reload for the same mode bypasses: the new value is used for that reload.
- rst mid-operation: immediate return to HOLD with the reset values above. Divisors return to their defaults.
- Steady state: strobe is never asserted while rst_out=1.

Test Plan:
- Reset, mode_in=0, DEFAULT_DIV=4 -> rst_out falls 3 cycles after rst; strobe in the first RUN cycle, then every 4 cycles; cnt sequence 0,3,2,1,0.
- mode_in 0->1 while cnt=2 -> switch_pend=1 for 2 cycles; strobe at cnt=0 still on schedule; then strobe every cycle; mode_active=1.
- cfg_we, cfg_mode=3, cfg_div=6 while mode 3 is active with cnt=1 -> next period still 1 cycle; following periods 6 cycles. Same write on a cnt==0 cycle -> the 6-cycle period starts immediately.
- cfg_div=0 for mode 0 -> strobe every cycle (div_eff=1). cfg_mode=5 with NUM_MODES=4 -> no divisor changes.
- mode_in toggles 0->2->0 within one 4-cycle period -> no switch; mode_active stays 0; period unchanged.
- rst asserted mid-period in mode 3 with div=6 -> next cycle strobe=0, rst_out=1, cnt=0; after release all divisors are back at their defaults.
